button_capture_module: RTL

Input-side counterpart of the LED display: captures the four colour push-buttons (G, Y, R, B) and records each player's entry in the same 6-bit, 3-colour packed format that the display path consumes. Raw button pins are synchronised, debounced and edge-detected, and each press is encoded to a 2-bit colour. Each accepted press is written into the active player's sequence register and flagged with a single-cycle pulse. The block sits between the board buttons and the game controller, beside the LED display block.

---
 rtl/genius_pkg.sv | 49 ++++
 rtl/debounce_module.sv | 47 ++++
 rtl/button_capture_module.sv | 101 ++++++++++
 3 files changed

// File: rtl/genius_pkg.sv
// Shared types and constants for the Genius button capture path.
// Colour codes match the LED bit index used by the display block.
package genius_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10,
    BLUE   = 2'b11
  } color_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } cap_state_t;

  localparam logic [1:0] P1 = 2'd0;
  localparam logic [1:0] P2 = 2'd1;

  localparam int DEBOUNCE_DEFAULT = 2_000_000;

  // Only meaningful for a one-hot vector; callers qualify with a one-hot check.
  function automatic color_t encode_btn(input logic [3:0] btn);
    color_t c;
    c = GREEN;
    case (btn)
      4'b0010: c = YELLOW;
      4'b0100: c = RED;
      4'b1000: c = BLUE;
      default: c = GREEN;
    endcase
    return c;
  endfunction

  function automatic logic [5:0] insert_entry(input logic [5:0] seq,
                                              input logic [1:0] idx,
                                              input color_t     color);
    logic [5:0] s;
    s = seq;
    case (idx)
      2'd0:    s[1:0] = color;
      2'd1:    s[3:2] = color;
      2'd2:    s[5:4] = color;
      default: s = seq;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/debounce_module.sv
// Two-flop synchroniser followed by a stability counter for one raw button.
// The level flips only after the synchronised input has disagreed long enough.
module debounce_module
  import genius_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the current level restarts the count.
      if (r_sync2 != r_level) begin
        if (r_cnt == TC) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/button_capture_module.sv
// Captures debounced colour button presses into per-player 3-entry sequences.
//   state  | meaning
//   S_IDLE | all buttons released; next single rising button is a press
//   S_HELD | a button is down; wait for all-released before re-arming
module button_capture_module
  import genius_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_btn,
  input  logic [1:0] i_player,
  input  logic       i_clear,
  output logic [5:0] o_seq_p1,
  output logic [5:0] o_seq_p2,
  output logic       o_press,
  output logic [1:0] o_color,
  output logic       o_done_p1,
  output logic       o_done_p2
);

  logic [3:0] w_deb;
  logic       w_onehot;
  logic       w_accept;
  color_t     w_color;
  logic       w_sel_p1;
  logic       w_sel_p2;

  cap_state_t r_state;
  logic [5:0] r_seq_p1;
  logic [5:0] r_seq_p2;
  logic [1:0] r_cnt_p1;
  logic [1:0] r_cnt_p2;
  logic       r_press;
  logic [1:0] r_color;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    debounce_module #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_raw   (i_btn[g]),
      .o_level (w_deb[g])
    );
  end

  assign w_onehot = (w_deb != 4'b0000) && ((w_deb & (w_deb - 4'd1)) == 4'b0000);
  assign w_accept = (r_state == S_IDLE) && w_onehot;
  assign w_color  = encode_btn(w_deb);
  assign w_sel_p1 = (i_player == P1);
  assign w_sel_p2 = (i_player == P2);

  // A multi-bit rise still moves to S_HELD so it can never become a press later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_press <= 1'b0;
      r_color <= 2'b00;
    end else begin
      r_press <= w_accept;
      if (w_accept) r_color <= w_color;
      case (r_state)
        S_IDLE:  if (w_deb != 4'b0000) r_state <= S_HELD;
        S_HELD:  if (w_deb == 4'b0000) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_seq_p1 <= 6'd0;
      r_cnt_p1 <= 2'd0;
      r_seq_p2 <= 6'd0;
      r_cnt_p2 <= 2'd0;
    end else begin
      if (w_sel_p1 && i_clear) begin
        r_seq_p1 <= 6'd0;
        r_cnt_p1 <= 2'd0;
      end else if (w_sel_p1 && w_accept && (r_cnt_p1 != 2'd3)) begin
        r_seq_p1 <= insert_entry(r_seq_p1, r_cnt_p1, w_color);
        r_cnt_p1 <= r_cnt_p1 + 2'd1;
      end
      if (w_sel_p2 && i_clear) begin
        r_seq_p2 <= 6'd0;
        r_cnt_p2 <= 2'd0;
      end else if (w_sel_p2 && w_accept && (r_cnt_p2 != 2'd3)) begin
        r_seq_p2 <= insert_entry(r_seq_p2, r_cnt_p2, w_color);
        r_cnt_p2 <= r_cnt_p2 + 2'd1;
      end
    end
  end

  assign o_seq_p1  = r_seq_p1;
  assign o_seq_p2  = r_seq_p2;
  assign o_press   = r_press;
  assign o_color   = r_color;
  assign o_done_p1 = (r_cnt_p1 == 2'd3);
  assign o_done_p2 = (r_cnt_p2 == 2'd3);

endmodule
